// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: imem request/response, decode handshake and redirect.
// The fetch unit connects through the master modport; the environment uses slave.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    input  redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, id_valid, id_instr, id_pc, pc_out
  );

  modport slave (
    output redirect, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, id_valid, id_instr, id_pc, pc_out
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: fetch PC, imem request FSM, instruction buffer, decode handshake.
// Optional FETCH_PERF_EN adds saturating bubble/flush counters.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0] bubble_cnt,
  output logic [15:0] flush_cnt
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              imem_req_q, imem_req_d;
  logic              id_valid_q, id_valid_d;
  logic [DATA_W-1:0] id_instr_q, id_instr_d;
  logic [ADDR_W-1:0] id_pc_q, id_pc_d;

  logic grant;
  logic push;
  logic pop;
  logic credit;

  // Next-state, buffer update and registered-output precompute
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    push       = 1'b0;
    pop        = id_valid_q && bus.id_ready;
    grant      = (state_q == REQ) && bus.imem_gnt;
    credit     = 1'b0;

    unique case (state_q)
      IDLE: ;
      REQ: begin
        if (grant) begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(2);
          req_addr_d = fetch_pc_q;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) push = 1'b1;
      end
      DROP: begin
        if (bus.imem_rvalid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = '{instr: bus.imem_rdata, pc: req_addr_q};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    occ_d  = occ_q + OCC_W'(push) - OCC_W'(pop);
    credit = (occ_d < OCC_W'(DEPTH));

    // Only one request is ever outstanding, so credit only needs the occupancy
    if (state_q == IDLE && credit) state_d = REQ;
    if (state_q == WAIT && push)   state_d = credit ? REQ : IDLE;

    // Redirect overrides everything: flush buffer, restart at the new PC
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc & ~ADDR_W'(1);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      occ_d      = '0;
      unique case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = grant ? DROP : REQ;
        WAIT:    state_d = bus.imem_rvalid ? REQ : DROP;
        DROP:    state_d = DROP;
        default: state_d = IDLE;
      endcase
    end

    imem_req_d = (state_d == REQ);
    id_valid_d = (occ_d != '0);
    id_instr_d = mem_d[rd_ptr_d].instr;
    id_pc_d    = mem_d[rd_ptr_d].pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      imem_req_q <= 1'b0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      imem_req_q <= imem_req_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  assign bus.imem_req  = imem_req_q;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.pc_out    = fetch_pc_q;
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;

`ifdef FETCH_PERF_EN
  logic [15:0] bubble_q, bubble_d;
  logic [15:0] flush_q, flush_d;

  // Saturating counters for decode bubbles and redirects
  always_comb begin
    bubble_d = bubble_q;
    flush_d  = flush_q;
    if (!id_valid_q && bus.id_ready && bubble_q != 16'hFFFF) bubble_d = bubble_q + 16'd1;
    if (bus.redirect && flush_q != 16'hFFFF)                 flush_d  = flush_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      bubble_q <= bubble_d;
      flush_q  <= flush_d;
    end
  end

  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (default and RESET_PC=0xFFFE instances).
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

`ifdef FETCH_PERF_EN
  logic [15:0] bubble_cnt, flush_cnt, bubble2, flush2;
`endif

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
`ifdef FETCH_PERF_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'hFFFE), .DEPTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2)
`ifdef FETCH_PERF_EN
    , .bubble_cnt(bubble2), .flush_cnt(flush2)
`endif
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] gq [$];
  logic [15:0] g2q [$];
  logic [31:0] pq [$];
  int          rsp_delay;
  bit          pend;
  int          pcnt;
  logic [15:0] pdata;
  bit          saw_rvalid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock: log grants/pops seen at the edge, then model imem responses
  task automatic cyc();
    logic g, g2;
    logic [15:0] ga, ga2;
    g   = rst_n && bus.imem_req && bus.imem_gnt;
    ga  = bus.imem_addr;
    g2  = rst_n && bus2.imem_req && bus2.imem_gnt;
    ga2 = bus2.imem_addr;
    if (rst_n && bus.id_valid && bus.id_ready && !bus.redirect)
      pq.push_back({bus.id_pc, bus.id_instr});
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    if (g) begin
      gq.push_back(ga);
      pend  = 1'b1;
      pcnt  = rsp_delay;
      pdata = ga ^ 16'h5A00;
    end
    if (pend) begin
      if (pcnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = pdata;
        pend            = 1'b0;
      end else pcnt--;
    end
    if (bus.imem_rvalid && rst_n) saw_rvalid = 1'b1;
    bus2.imem_rvalid = g2;
    bus2.imem_rdata  = g2 ? (ga2 ^ 16'h5A00) : 16'h0000;
    if (g2) g2q.push_back(ga2);
  endtask

  task automatic do_reset(input string tag);
    rst_n           = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.id_ready    = 1'b0;
    pend            = 1'b0;
    rsp_delay       = 0;
    gq.delete();
    g2q.delete();
    pq.delete();
    cyc();
    cyc();
    chk({tag, "_rst_req"},   32'(bus.imem_req), 32'd0);
    chk({tag, "_rst_valid"}, 32'(bus.id_valid), 32'd0);
    chk({tag, "_rst_instr"}, 32'(bus.id_instr), 32'd0);
    chk({tag, "_rst_idpc"},  32'(bus.id_pc),    32'd0);
    chk({tag, "_rst_pc"},    32'(bus.pc_out),   32'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    int idx;
    int bad;
    rst_n            = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = '0;
    bus2.imem_gnt    = 1'b1;
    bus2.id_ready    = 1'b1;
    bus2.imem_rvalid = 1'b0;
    bus2.imem_rdata  = '0;

    // Streaming: immediate grant, 1-cycle response, decode always ready
    do_reset("s1");
    chk("s2_rst_pc", 32'(bus2.pc_out), 32'h0000FFFE);
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    repeat (14) cyc();
    chk("s1_ngrant", 32'(gq.size() >= 3), 32'd1);
    chk("s1_addr0", 32'(gq[0]), 32'h0000);
    chk("s1_addr1", 32'(gq[1]), 32'h0002);
    chk("s1_addr2", 32'(gq[2]), 32'h0004);
    chk("s1_npop", 32'(pq.size() >= 3), 32'd1);
    chk("s1_pop0", pq[0], 32'h0000_5A00);
    chk("s1_pop1", pq[1], 32'h0002_5A02);
    chk("s1_pop2", pq[2], 32'h0004_5A04);
    chk("wrap_addr0", 32'(g2q[0]), 32'h0000FFFE);
    chk("wrap_addr1", 32'(g2q[1]), 32'h00000000);

    // Decode stalled: exactly two buffered, then request stops
    do_reset("s2");
    bus.imem_gnt = 1'b1;
    repeat (10) cyc();
    chk("s2_ngrant", 32'(gq.size()), 32'd2);
    chk("s2_req_off", 32'(bus.imem_req), 32'd0);
    chk("s2_valid", 32'(bus.id_valid), 32'd1);
    chk("s2_head", {bus.id_pc, bus.id_instr}, 32'h0000_5A00);
    bus.id_ready = 1'b1;
    repeat (12) cyc();
    chk("s2_npop", 32'(pq.size() >= 3), 32'd1);
    chk("s2_pop0", pq[0], 32'h0000_5A00);
    chk("s2_pop1", pq[1], 32'h0002_5A02);
    chk("s2_pop2", pq[2], 32'h0004_5A04);
    chk("s2_resume", 32'(gq[2]), 32'h0004);

    // Grant withheld: address must hold stable
    do_reset("s3");
    bus.id_ready = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("s3_req_hold", 32'(bus.imem_req), 32'd1);
      chk("s3_addr_hold", 32'(bus.imem_addr), 32'h0000);
      cyc();
    end
    bus.imem_gnt = 1'b1;
    cyc();
    bus.imem_gnt = 1'b0;
    repeat (6) cyc();
    chk("s3_ngrant", 32'(gq.size()), 32'd1);
    chk("s3_npop", 32'(pq.size()), 32'd1);
    chk("s3_pop0", pq[0], 32'h0000_5A00);
    chk("s3_next_addr", 32'(bus.imem_addr), 32'h0002);
    chk("s3_pc_out", 32'(bus.pc_out), 32'h0002);

    // Redirect while waiting on the response for 0x0004
    do_reset("s4");
    rsp_delay    = 3;
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 60; i++) if (gq.size() < 3) cyc();
    chk("s4_reach_wait", 32'(gq.size()), 32'd3);
    chk("s4_wait_addr", 32'(gq[2]), 32'h0004);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h1235;
    idx = pq.size();
    cyc();
    bus.redirect = 1'b0;
    chk("s4_drop_req", 32'(bus.imem_req), 32'd0);
    chk("s4_flush_valid", 32'(bus.id_valid), 32'd0);
    chk("s4_pc_out", 32'(bus.pc_out), 32'h1234);
    repeat (20) cyc();
    chk("s4_ngrant", 32'(gq.size() >= 4), 32'd1);
    chk("s4_new_addr", 32'(gq[3]), 32'h1234);
    chk("s4_npop", 32'(pq.size() > idx), 32'd1);
    chk("s4_first_pop", pq[idx], 32'h1234_4834);
    bad = 0;
    foreach (pq[i]) if (pq[i][31:16] == 16'h0004) bad++;
    chk("s4_no_stale", 32'(bad), 32'd0);
`ifdef FETCH_PERF_EN
    chk("s4_flush_cnt", 32'(flush_cnt), 32'd1);
`endif

    // Reset mid-WAIT; late response must be ignored
    do_reset("s6");
    rsp_delay    = 3;
    bus.imem_gnt = 1'b1;
    bus.id_ready = 1'b1;
    for (int i = 0; i < 20; i++) if (gq.size() < 1) cyc();
    chk("s6_reach_wait", 32'(gq.size()), 32'd1);
    bus.imem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("s6_abort_req", 32'(bus.imem_req), 32'd0);
    chk("s6_abort_pc", 32'(bus.pc_out), 32'h0002 & 32'h0);
    cyc();
    cyc();
    saw_rvalid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("s6_valid_low", 32'(bus.id_valid), 32'd0);
    end
    chk("s6_rvalid_seen", 32'(saw_rvalid), 32'd1);
    chk("s6_req", 32'(bus.imem_req), 32'd1);
    chk("s6_addr", 32'(bus.imem_addr), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
